// File: rtl/execute_muldiv_if.sv
// Request/response bundle for execute_muldiv: op issue, HI/LO read port and status.
interface execute_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rd_sel;
  logic [WIDTH-1:0] rd_data;
  logic             rd_stall;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b, rd_sel,
    input  rd_data, rd_stall, busy, done
  );

  modport slave (
    input  start, op, a, b, rd_sel,
    output rd_data, rd_stall, busy, done
  );
endinterface

// File: rtl/execute_muldiv.sv
// Multi-cycle multiply/divide unit owning HI/LO; one shift-add / restoring-subtract step per cycle.
// Define MULDIV_SIGNED_EN to give MULT/DIV signed semantics; otherwise they alias MULTU/DIVU.
module execute_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clock,
  input  logic            reset,
  execute_muldiv_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               bzero_q, bzero_d;
  logic               done_q, done_d;
`ifdef MULDIV_SIGNED_EN
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic               sa, sb;
`endif

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     add_sum, sub_trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    bzero_d  = bzero_q;
    done_d   = 1'b0;
`ifdef MULDIV_SIGNED_EN
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    sa        = bus.op[0] & bus.a[WIDTH-1];
    sb        = bus.op[0] & bus.b[WIDTH-1];
    mag_a     = sa ? ('0 - bus.a) : bus.a;
    mag_b     = sb ? ('0 - bus.b) : bus.b;
`else
    mag_a     = bus.a;
    mag_b     = bus.b;
`endif

    // Shared datapath: acc_hi is the partial product / remainder, acc_lo the multiplier / quotient.
    add_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    sub_trial = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, opnd_q};
    prod      = {acc_hi_q, acc_lo_q};
    quo       = acc_lo_q;
    rem       = acc_hi_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (!bus.op[2]) begin
            state_d  = S_RUN;
            cnt_d    = '0;
            is_div_d = bus.op[1];
            bzero_d  = (bus.b == '0);
            acc_hi_d = '0;
            acc_lo_d = bus.op[1] ? mag_a : mag_b;
            opnd_d   = bus.op[1] ? mag_b : mag_a;
`ifdef MULDIV_SIGNED_EN
            neg_d     = sa ^ sb;
            neg_rem_d = sa;
`endif
          end else if (!bus.op[1]) begin
            if (bus.op[0]) lo_d = bus.a;
            else           hi_d = bus.a;
          end
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          if (!sub_trial[WIDTH]) begin
            acc_hi_d = sub_trial[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = add_sum[WIDTH:1];
          acc_lo_d = {add_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
`ifdef MULDIV_SIGNED_EN
        if (neg_q) begin
          prod = '0 - prod;
          quo  = '0 - quo;
        end
        if (neg_rem_q) rem = '0 - rem;
`endif
        // Divide by zero leaves rem == |a|, so only the quotient needs forcing.
        if (is_div_q) begin
          hi_d = rem;
          lo_d = bzero_q ? '1 : quo;
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      bzero_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      bzero_q  <= bzero_d;
      done_q   <= done_d;
    end
  end

`ifdef MULDIV_SIGNED_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`endif

  always_comb begin
    bus.rd_data  = bus.rd_sel ? hi_q : lo_q;
    bus.busy     = (state_q != S_IDLE);
    bus.rd_stall = (state_q != S_IDLE);
    bus.done     = done_q;
  end
endmodule

// File: tb/tb_execute_muldiv.sv
// Scoreboard bench for execute_muldiv: expected HI/LO queued at issue, compared at done.
module tb_execute_muldiv;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  execute_muldiv_if #(.WIDTH(W)) bus ();

  execute_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic        sgn;
    logic [31:0] ma, mb, q, r;
`ifdef MULDIV_SIGNED_EN
    sgn = op[0];
`else
    sgn = 1'b0;
`endif
    if (!op[1]) begin
      if (sgn) return {{32{a[31]}}, a} * {{32{b[31]}}, b};
      return {32'd0, a} * {32'd0, b};
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
    ma = a[31] ? -a : a;
    mb = b[31] ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (a[31] ^ b[31]) q = -q;
    if (a[31]) r = -r;
    return {r, q};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mt(input logic to_lo, input logic [W-1:0] v);
    bus.start = 1'b1;
    bus.op    = to_lo ? 3'b101 : 3'b100;
    bus.a     = v;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [63:0] exp);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    exp_q.push_back(exp);
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.rd_stall !== 1'b1)
      $display("FAIL issue_busy op=%0d busy=%b rd_stall=%b required 1/1", op, bus.busy, bus.rd_stall);
    else passed++;
  endtask

  // Scoreboard consumer: waits (bounded) for done, checks latency, pops and compares HI/LO.
  task automatic collect(input int elapsed);
    int          n = elapsed;
    logic        busy_ok = 1'b1;
    logic [63:0] exp, got;
    while (bus.done !== 1'b1 && n < int'(W) + 10) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      tick();
      n++;
    end
    checks++;
    if (bus.done !== 1'b1 || n != int'(W) + 1)
      $display("FAIL latency done=%b cycles=%0d required %0d", bus.done, n, W + 1);
    else passed++;
    checks++;
    if (!busy_ok || bus.busy !== 1'b0)
      $display("FAIL busy_window in_flight_ok=%b busy_at_done=%b required 1/0", busy_ok, bus.busy);
    else passed++;
    bus.rd_sel = 1'b1;
    #1 got[63:32] = bus.rd_data;
    bus.rd_sel = 1'b0;
    #1 got[31:0] = bus.rd_data;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard_empty got=%h", got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) $display("FAIL result hi_lo=%h required %h", got, exp);
      else passed++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rd_stall !== 1'b0)
      $display("FAIL reset_flags busy=%b done=%b rd_stall=%b required 0/0/0", bus.busy, bus.done, bus.rd_stall);
    else passed++;
    bus.rd_sel = 1'b1;
    #1;
    checks++;
    if (bus.rd_data !== '0) $display("FAIL reset_hi got=%h required 0", bus.rd_data);
    else passed++;
    bus.rd_sel = 1'b0;
    #1;
    checks++;
    if (bus.rd_data !== '0) $display("FAIL reset_lo got=%h required 0", bus.rd_data);
    else passed++;
  endtask

  task automatic test_mthi_mtlo;
    mt(1'b0, 32'h0000_1234);
    mt(1'b1, 32'h0000_5678);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL mt_flags busy=%b done=%b required 0/0", bus.busy, bus.done);
    else passed++;
    // reserved op must not touch HI/LO
    bus.start = 1'b1;
    bus.op    = 3'b110;
    bus.a     = 32'hDEAD_BEEF;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL reserved_busy got=%b required 0", bus.busy);
    else passed++;
    bus.rd_sel = 1'b1;
    #1;
    checks++;
    if (bus.rd_data !== 32'h0000_1234) $display("FAIL mthi got=%h required 00001234", bus.rd_data);
    else passed++;
    bus.rd_sel = 1'b0;
    #1;
    checks++;
    if (bus.rd_data !== 32'h0000_5678) $display("FAIL mtlo got=%h required 00005678", bus.rd_data);
    else passed++;
  endtask

  task automatic test_mult;
    issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    collect(0);
`ifdef MULDIV_SIGNED_EN
    issue(3'b001, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB);
`else
    issue(3'b001, 32'hFFFF_FFFD, 32'h0000_0007, 64'h0000_0006_FFFF_FFEB);
`endif
    collect(0);
  endtask

  task automatic test_div;
`ifdef MULDIV_SIGNED_EN
    issue(3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD);
    collect(0);
    issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    collect(0);
`else
    issue(3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 64'h0000_0001_7FFF_FFFC);
    collect(0);
`endif
    issue(3'b010, 32'd1000, 32'd7, 64'h0000_0006_0000_008E);
    collect(0);
  endtask

  task automatic test_divzero;
    issue(3'b010, 32'h0000_0064, 32'h0, 64'h0000_0064_FFFF_FFFF);
    collect(0);
    issue(3'b011, 32'hFFFF_FFFB, 32'h0, 64'hFFFF_FFFB_FFFF_FFFF);
    collect(0);
  endtask

  task automatic test_busy_ignored;
    mt(1'b0, 32'hAAAA_5555);
    issue(3'b010, 32'd1000, 32'd7, 64'h0000_0006_0000_008E);
    bus.rd_sel = 1'b1;
    #1;
    checks++;
    if (bus.rd_stall !== 1'b1 || bus.rd_data !== 32'hAAAA_5555)
      $display("FAIL stale_read rd_stall=%b hi=%h required 1/aaaa5555", bus.rd_stall, bus.rd_data);
    else passed++;
    bus.start = 1'b1;
    bus.op    = 3'b100;
    bus.a     = 32'h0000_1234;
    tick();
    bus.start = 1'b0;
    collect(1);
  endtask

  task automatic test_abort;
    logic saw_done = 1'b0;
    mt(1'b0, 32'h1111_1111);
    mt(1'b1, 32'h2222_2222);
    issue(3'b010, 32'h0000_0064, 32'd3, 64'h0);
    repeat (9) begin
      tick();
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || saw_done)
      $display("FAIL abort_flags busy=%b done=%b early_done=%b required 0/0/0", bus.busy, bus.done, saw_done);
    else passed++;
    bus.rd_sel = 1'b1;
    #1;
    checks++;
    if (bus.rd_data !== '0) $display("FAIL abort_hi got=%h required 0", bus.rd_data);
    else passed++;
    bus.rd_sel = 1'b0;
    #1;
    checks++;
    if (bus.rd_data !== '0) $display("FAIL abort_lo got=%h required 0", bus.rd_data);
    else passed++;
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL abort_quiet done=%b busy=%b required 0/0", bus.done, bus.busy);
    else passed++;
    issue(3'b010, 32'h0000_0064, 32'd3, 64'h0000_0001_0000_0021);
    collect(0);
  endtask

  task automatic test_back_to_back;
    issue(3'b000, 32'd12345, 32'd678, model(3'b000, 32'd12345, 32'd678));
    collect(0);
    issue(3'b010, 32'hFFFF_0000, 32'd255, model(3'b010, 32'hFFFF_0000, 32'd255));
    collect(0);
    tick();
    checks++;
    if (bus.done !== 1'b0) $display("FAIL done_pulse got=%b required 0", bus.done);
    else passed++;
  endtask

  task automatic test_random;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 3 == 0) ? W'($urandom_range(1, 20)) : $urandom;
      if (i % 4 == 1) b = -b;
      issue(op, a, b, model(op, a, b));
      collect(0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start  = 1'b0;
    bus.op     = 3'b000;
    bus.a      = '0;
    bus.b      = '0;
    bus.rd_sel = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_div();
    test_divzero();
    test_busy_ignored();
    test_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
